// File: rtl/cache_pkg.sv
// Shared cache-controller definitions: fill FSM states and block geometry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cache_pkg;

  // 16-bit words per cache block and byte-offset bits of a block address
  localparam int BLOCK_WORDS       = 8;
  localparam int BLOCK_OFFSET_BITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear, used to track issued and received fill words.
// Latency: count visible the cycle after the enabling edge.
// Backpressure: none; enable is ignored once MAX is reached, clear has priority.
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step up until saturated at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// I-cache miss handler: streams one block of word reads to memory and writes returning words into the cache.
// Latency: first read the cycle after the miss; data/tag writes combinational with each memory valid.
// Backpressure: none towards memory; fsm_busy stalls fetch. Optional miss counter under FILL_MISS_CNT_EN.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic [ADDR_W-1:0] memory_address,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [15:0]       cache_data,
  output logic              write_data_array,
  output logic              write_tag_array
`ifdef FILL_MISS_CNT_EN
  ,
  output logic [15:0]       miss_count
`endif
);

  import cache_pkg::*;

  localparam int            CW     = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] BW_V   = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_V = CW'(BLOCK_WORDS - 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     issue_cnt, recv_cnt;
  logic              start, issue_en, recv_en;

  // Offset bits of the miss address are dropped: the fill always starts at word 0
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[BLOCK_OFFSET_BITS-1:0];

  assign start    = (state_q == IDLE) && miss_detected;
  assign issue_en = (state_q == FILL) && (issue_cnt < BW_V);
  assign recv_en  = (state_q == FILL) && memory_data_valid;

  fill_counter #(.W(CW), .MAX(BLOCK_WORDS)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (issue_en),
    .cnt_o (issue_cnt)
  );

  fill_counter #(.W(CW), .MAX(BLOCK_WORDS)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (recv_en),
    .cnt_o (recv_cnt)
  );

  // Next state, block base capture and the per-cycle memory/cache strobes
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_addr  = '0;
    cache_data       = '0;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = {miss_address[ADDR_W-1:BLOCK_OFFSET_BITS], BLOCK_OFFSET_BITS'(0)};
          state_d = FILL;
        end
      end
      FILL: begin
        if (issue_en) begin
          memory_read_en = 1'b1;
          memory_address = base_q + ADDR_W'({issue_cnt, 1'b0});
        end
        if (recv_en) begin
          write_data_array = 1'b1;
          cache_word_addr  = base_q + ADDR_W'({recv_cnt, 1'b0});
          cache_data       = memory_data;
          // Tag/valid goes in with the final data word; the block is only valid once complete
          if (recv_cnt == LAST_V) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and base-address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign fsm_busy = (state_q == FILL);

`ifdef FILL_MISS_CNT_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  assign miss_cnt_d = write_tag_array ? miss_cnt_q + 16'd1 : miss_cnt_q;

  // Completed-fill counter, wraps at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`endif

endmodule
